// File: rtl/secuenciador_juego.sv
// secuenciador_juego: round FSM, lives/level counters and step/repaint strobes for the car-dodging game.
// Define SECUENCIADOR_PAUSA_EN to add the iPausa input and the PAUSA state.
module secuenciador_juego #(
    parameter int VIDAS_INI     = 3,
    parameter int PASOS_NIVEL   = 8,
    parameter int NIVEL_MAX     = 7,
    parameter int PERIODO_BASE  = 8,
    parameter int FRAMES_GRACIA = 60
) (
    input  logic       iClk,
    input  logic       iReset,
    input  logic       iStart,
    input  logic       iChoque,
    input  logic       iPunto,
    input  logic       iFrame,
`ifdef SECUENCIADOR_PAUSA_EN
    input  logic       iPausa,
`endif
    output logic [2:0] oEstado,
    output logic       oPaso,
    output logic       oPasoJugador,
    output logic       oEnableLFSR,
    output logic       oPintar,
    output logic       oResetPintar,
    output logic [2:0] oNivel,
    output logic [1:0] oVidas
);
    localparam logic [2:0] IDLE = 3'd0, CARGA = 3'd1, JUEGO = 3'd2, CHOQUE = 3'd3, FIN = 3'd4, PAUSA = 3'd5;
    localparam int FW = $clog2(PERIODO_BASE + 1);
    localparam int SW = $clog2(PASOS_NIVEL + 1);
    localparam int GW = ($clog2(FRAMES_GRACIA + 1) < 4) ? 4 : $clog2(FRAMES_GRACIA + 1);

    function automatic logic [FW-1:0] periodo(input logic [2:0] n);
        periodo = (PERIODO_BASE > int'(n) + 1) ? FW'(PERIODO_BASE - int'(n)) : FW'(1);
    endfunction

    logic          start_prev, start_ev;
    logic [FW-1:0] frame_cnt, frame_n, p_cur, p_n;
    logic [SW-1:0] score, score_n;
    logic [GW-1:0] grace, grace_n;
    logic [2:0]    estado_n, nivel_n;
    logic [1:0]    vidas_n;
    logic          paso_n, pj_n, pintar_n;

    assign start_ev = iStart & ~start_prev;
`ifdef SECUENCIADOR_PAUSA_EN
    logic pausa_prev, pausa_ev;
    assign pausa_ev = iPausa & ~pausa_prev;
    always_ff @(posedge iClk or negedge iReset)
        if (!iReset) pausa_prev <= 1'b1;
        else         pausa_prev <= iPausa;
`endif

    always_comb begin
        estado_n = oEstado;
        frame_n  = frame_cnt;
        p_n      = p_cur;
        score_n  = score;
        grace_n  = grace;
        nivel_n  = oNivel;
        vidas_n  = oVidas;
        paso_n   = 1'b0;
        pj_n     = 1'b0;
        case (oEstado)
            IDLE: if (start_ev) begin
                vidas_n  = 2'(VIDAS_INI);
                nivel_n  = 3'd0;
                score_n  = '0;
                estado_n = CARGA;
            end
            CARGA: begin
                frame_n  = '0;
                p_n      = periodo(oNivel);
                estado_n = JUEGO;
            end
            JUEGO: begin
`ifdef SECUENCIADOR_PAUSA_EN
                if (pausa_ev) estado_n = PAUSA;
                else begin
`else
                begin
`endif
                    // the point is scored before a same-cycle crash is applied
                    if (iPunto) begin
                        score_n = (score == SW'(PASOS_NIVEL - 1)) ? '0 : score + 1'b1;
                        if (score == SW'(PASOS_NIVEL - 1) && oNivel < 3'(NIVEL_MAX)) nivel_n = oNivel + 3'd1;
                    end
                    if (iChoque) begin
                        vidas_n  = oVidas - 2'd1;
                        grace_n  = '0;
                        estado_n = (oVidas == 2'd1) ? FIN : CHOQUE;
                    end else if (iFrame) begin
                        pj_n = 1'b1;
                        // the period length is latched at each wrap so a level change applies to the next period
                        if (frame_cnt == p_cur - 1'b1) begin
                            frame_n = '0;
                            paso_n  = 1'b1;
                            p_n     = periodo(nivel_n);
                        end else frame_n = frame_cnt + 1'b1;
                    end
                end
            end
            CHOQUE: if (iFrame) begin
                if (grace == GW'(FRAMES_GRACIA - 1)) estado_n = CARGA;
                else grace_n = grace + 1'b1;
            end
            FIN: if (start_ev) estado_n = IDLE;
`ifdef SECUENCIADOR_PAUSA_EN
            PAUSA: if (pausa_ev) estado_n = JUEGO;
`endif
            default: estado_n = IDLE;
        endcase
    end

    assign pintar_n = (estado_n == JUEGO) || (estado_n == FIN) || (estado_n == PAUSA) ||
                      (estado_n == CHOQUE && grace_n[3]);

    always_ff @(posedge iClk or negedge iReset)
        if (!iReset) begin
            start_prev   <= 1'b1;
            oEstado      <= IDLE;
            frame_cnt    <= '0;
            p_cur        <= FW'(PERIODO_BASE);
            score        <= '0;
            grace        <= '0;
            oNivel       <= 3'd0;
            oVidas       <= 2'(VIDAS_INI);
            oPaso        <= 1'b0;
            oPasoJugador <= 1'b0;
            oEnableLFSR  <= 1'b0;
            oPintar      <= 1'b0;
            oResetPintar <= 1'b0;
        end else begin
            start_prev   <= iStart;
            oEstado      <= estado_n;
            frame_cnt    <= frame_n;
            p_cur        <= p_n;
            score        <= score_n;
            grace        <= grace_n;
            oNivel       <= nivel_n;
            oVidas       <= vidas_n;
            oPaso        <= paso_n;
            oPasoJugador <= pj_n;
            oEnableLFSR  <= (estado_n == JUEGO);
            oPintar      <= pintar_n;
            oResetPintar <= (estado_n == CARGA);
        end
endmodule

// File: tb/tb_secuenciador_juego.sv
// tb_secuenciador_juego: vector table plus scripted rounds for secuenciador_juego.
module tb_secuenciador_juego;
    localparam logic [2:0] IDLE = 3'd0, CARGA = 3'd1, JUEGO = 3'd2, CHOQUE = 3'd3, FIN = 3'd4, PAUSA = 3'd5;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b1, choque = 1'b0, punto = 1'b0, frame = 1'b0, pausa = 1'b0;
    logic [2:0] estado, nivel;
    logic [1:0] vidas;
    logic paso, paso_j, lfsr, pintar, rst_pintar;

    typedef struct {
        logic st, ch, pu, fr, pz;
        logic [2:0] es;
        logic pa, pj, lf, pi, rp;
        logic [2:0] nv;
        logic [1:0] vd;
        string name;
    } vec_t;

    vec_t q[$];
    vec_t tbl[5];
    int vectors = 0, miscompares = 0;
    logic [2:0] en = 3'd0;
    logic [1:0] ev = 2'd3;

    secuenciador_juego dut (
        .iClk(clk), .iReset(rst_n), .iStart(start), .iChoque(choque), .iPunto(punto), .iFrame(frame),
`ifdef SECUENCIADOR_PAUSA_EN
        .iPausa(pausa),
`endif
        .oEstado(estado), .oPaso(paso), .oPasoJugador(paso_j), .oEnableLFSR(lfsr),
        .oPintar(pintar), .oResetPintar(rst_pintar), .oNivel(nivel), .oVidas(vidas)
    );

    always #20 clk = ~clk;

    task automatic apply(input vec_t v);
        vec_t e;
        start = v.st; choque = v.ch; punto = v.pu; frame = v.fr; pausa = v.pz;
        q.push_back(v);
        @(posedge clk);
        @(negedge clk);
        e = q.pop_front();
        vectors++;
        if ({estado, paso, paso_j, lfsr, pintar, rst_pintar, nivel, vidas} !==
            {e.es, e.pa, e.pj, e.lf, e.pi, e.rp, e.nv, e.vd}) begin
            miscompares++;
            $display("FAIL %s: got estado=%0d paso=%b pj=%b lfsr=%b pintar=%b rp=%b nivel=%0d vidas=%0d, expected estado=%0d paso=%b pj=%b lfsr=%b pintar=%b rp=%b nivel=%0d vidas=%0d",
                     e.name, estado, paso, paso_j, lfsr, pintar, rst_pintar, nivel, vidas,
                     e.es, e.pa, e.pj, e.lf, e.pi, e.rp, e.nv, e.vd);
        end
    endtask

    task automatic step(input string name, input logic st, ch, pu, fr, input logic [2:0] es,
                        input logic pa, pj, lf, pi, rp);
        apply('{st, ch, pu, fr, pausa, es, pa, pj, lf, pi, rp, en, ev, name});
    endtask

    task automatic juego(input string name, input logic pu, fr, pa, pj);
        step(name, 1'b0, 1'b0, pu, fr, JUEGO, pa, pj, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic check_reset(input string name);
        vectors++;
        if ({estado, paso, paso_j, lfsr, pintar, rst_pintar, nivel, vidas} !== {IDLE, 5'b0, 3'd0, 2'd3}) begin
            miscompares++;
            $display("FAIL %s: got estado=%0d paso=%b pj=%b lfsr=%b pintar=%b rp=%b nivel=%0d vidas=%0d, expected reset values",
                     name, estado, paso, paso_j, lfsr, pintar, rst_pintar, nivel, vidas);
        end
    endtask

    task automatic grace_run(input string name);
        for (int g = 0; g < 60; g++)
            if (g < 59) step(name, 1'b0, g == 10, g == 20, 1'b1, CHOQUE, 1'b0, 1'b0, 1'b0, ((g + 1) >> 3) & 1, 1'b0);
            else        step(name, 1'b0, 1'b0, 1'b0, 1'b1, CARGA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd3, "held_start"};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 2'd3, "start_low"};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, CARGA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 2'd3, "start_edge"};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, JUEGO, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd3, "to_juego"};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, JUEGO, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 2'd3, "juego_idle"};
        repeat (2) @(negedge clk);
        check_reset("reset_held");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) apply(tbl[i]);
        for (int i = 0; i < 16; i++) begin
            juego($sformatf("frame%0d", i), 1'b0, 1'b1, (i + 1) % 8 == 0, 1'b1);
            juego("frame_gap", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 8; k++) begin
            en = 3'(k / 8);
            juego("punto_lvl1", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) juego("old_period8", 1'b0, 1'b1, i == 7, 1'b1);
        for (int i = 0; i < 7; i++) juego("period7", 1'b0, 1'b1, i == 6, 1'b1);
        for (int t = 9; t <= 64; t++) begin
            en = (t / 8 > 7) ? 3'd7 : 3'(t / 8);
            juego("punto_sat", 1'b1, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 7; i++) juego("old_period7", 1'b0, 1'b1, i == 6, 1'b1);
        for (int i = 0; i < 3; i++) juego("period1", 1'b0, 1'b1, 1'b1, 1'b1);
        ev = 2'd2;
        step("crash1_frame", 1'b0, 1'b1, 1'b0, 1'b1, CHOQUE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        grace_run("grace1");
        juego("reload1", 1'b0, 1'b0, 1'b0, 1'b0);
        juego("reload1_p1", 1'b0, 1'b1, 1'b1, 1'b1);
        ev = 2'd1;
        step("crash2", 1'b0, 1'b1, 1'b0, 1'b0, CHOQUE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        grace_run("grace2");
        juego("reload2", 1'b0, 1'b0, 1'b0, 1'b0);
        ev = 2'd0;
        step("crash3_fin", 1'b0, 1'b1, 1'b0, 1'b0, FIN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("fin_frame", 1'b0, 1'b0, 1'b0, 1'b1, FIN, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("fin_start", 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("idle_held", 1'b1, 1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("idle_low", 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 3'd0; ev = 2'd3;
        step("restart", 1'b1, 1'b0, 1'b0, 1'b0, CARGA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        juego("replay", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 7; k++) juego("punto_pre", 1'b1, 1'b0, 1'b0, 1'b0);
        en = 3'd1; ev = 2'd2;
        step("punto_choque", 1'b0, 1'b1, 1'b1, 1'b0, CHOQUE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        grace_run("grace3");
        juego("reload3", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) juego("pre_reset", 1'b0, 1'b1, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        @(negedge clk);
        check_reset("reset_hold");
        rst_n = 1'b1;
        en = 3'd0; ev = 2'd3;
        step("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SECUENCIADOR_PAUSA_EN
        step("p_start", 1'b1, 1'b0, 1'b0, 1'b0, CARGA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        juego("p_juego", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) juego("p_frames", 1'b0, 1'b1, 1'b0, 1'b1);
        pausa = 1'b1;
        step("pause_edge", 1'b0, 1'b0, 1'b0, 1'b0, PAUSA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step("paused", 1'b0, i == 4, i == 6, 1'b1, PAUSA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pausa = 1'b0;
        step("pause_low", 1'b0, 1'b0, 1'b0, 1'b0, PAUSA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        pausa = 1'b1;
        juego("resume", 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) juego("resume_frames", 1'b0, 1'b1, i == 2, 1'b1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/secuenciador_juego.md
# secuenciador_juego

Game-level sequencer for the car-dodging game, clocked in the 25 MHz pixel domain. It owns the round state (idle, load, play, crash grace, game over), the lives and difficulty counters, and emits the step enables and repaint controls consumed by the obstacle registers, LFSR and player logic. It sits between the VGA sync generator, which supplies the frame pulse, and the obstacle/player datapath, which supplies the collision and score events.

## Interface
Parameters:
- VIDAS_INI, 3: lives loaded at game start (1..3).
- PASOS_NIVEL, 8: score pulses per difficulty level (>=1).
- NIVEL_MAX, 7: saturation value of oNivel (<=7).
- PERIODO_BASE, 8: frames per obstacle step at level 0 (>=1).
- FRAMES_GRACIA, 60: frames spent in CHOQUE (>=1).

Ports:
- iClk, in, 1: 25 MHz clock.
- iReset, in, 1: asynchronous, active-low reset.
- iStart, in, 1: debounced start button, level.
- iChoque, in, 1: collision flag, level.
- iPunto, in, 1: one-cycle pulse when an obstacle passes the player.
- iFrame, in, 1: one-cycle pulse per frame, at vertical blank start.
- oEstado, out, 3: encoding IDLE=0, CARGA=1, JUEGO=2, CHOQUE=3, FIN=4, PAUSA=5.
- oPaso, out, 1: one-cycle obstacle step enable.
- oPasoJugador, out, 1: one-cycle player step enable.
- oEnableLFSR, out, 1: LFSR run enable.
- oPintar, out, 1: draw obstacles and player.
- oResetPintar, out, 1: one-cycle pulse that reloads obstacle start positions.
- oNivel, out, 3: current difficulty level.
- oVidas, out, 2: lives remaining.

## Operation
- Start edge: the previous value of iStart is registered. That register resets to 1, so a button held through reset does not start a game. A start event is iStart=1 while the previous value was 0.
- IDLE: all strobes are 0, oPintar=0. A start event loads oVidas=VIDAS_INI, oNivel=0, clears the score counter, and moves to CARGA.
- CARGA: lasts exactly one cycle with oResetPintar=1. The frame counter is cleared. Next state is JUEGO.
- JUEGO: oPintar=1, oEnableLFSR=1.
  - Step period P = max(PERIODO_BASE - oNivel, 1) frames.
  - The frame counter increments on iFrame. The iFrame that completes P frames clears the counter and produces oPaso.
  - Every iFrame also produces oPasoJugador.
  - Each iPunto increments the score counter. On reaching PASOS_NIVEL the counter clears and oNivel increments, saturating at NIVEL_MAX.
  - iChoque=1 decrements oVidas. If the result is 0, go to FIN; otherwise go to CHOQUE.
- CHOQUE: no strobes; oEnableLFSR=0. Counts FRAMES_GRACIA frames. oPintar = bit 3 of the grace frame counter, so it blinks every 8 frames. iChoque and iPunto are ignored. At the end, go to CARGA; oNivel and oVidas are kept.
- FIN: oPintar=1 (frozen picture), no strobes. A start event goes to IDLE.
- Same-cycle events in JUEGO:
  - iPunto together with iChoque: the point is counted first, then the crash is processed.
  - iFrame together with iChoque: no step is emitted for that frame.
- Unknown oEstado encodings go to IDLE.

## Timing
- All outputs are registered.
- Reset values: oEstado=0, oVidas=VIDAS_INI, oNivel=0, and all other outputs 0.
- oPaso and oPasoJugador assert on the cycle after the qualifying iFrame, for exactly 1 cycle.
- oResetPintar asserts for exactly 1 cycle, the cycle oEstado=CARGA.
- Start event to oEstado=CARGA: 1 cycle. CARGA to JUEGO: 1 cycle.
- iChoque to the oVidas decrement and the state change: 1 cycle.
- The level change takes effect for the period that starts after the counter clears.
- Reset asserted mid-game returns every register to its reset value immediately, with no pulse emitted.

## Configuration
- SECUENCIADOR_PAUSA_EN defined:
  - Adds input iPausa (1 bit, debounced level). It has its own edge register, which resets to 1.
  - In JUEGO, a rising edge of iPausa enters PAUSA.
  - In PAUSA: oPintar=1 and oEnableLFSR=0; no strobes; frame, score, lives and level are frozen; iChoque is ignored.
  - Another rising edge of iPausa returns to JUEGO, resuming the same frame count.
- SECUENCIADOR_PAUSA_EN not defined: the port is absent and PAUSA is unreachable.

## Test plan
- Reset held with iStart=1, then released -> stays IDLE. Drop iStart, then raise it -> CARGA for 1 cycle with oResetPintar=1, then JUEGO, oVidas=3.
- JUEGO at oNivel=0 with 16 iFrame pulses -> 16 oPasoJugador pulses and 2 oPaso pulses, each 1 cycle after the 8th and 16th iFrame.
- 8 iPunto pulses -> oNivel=1 and P=7. Another 56 iPunto pulses -> oNivel saturates at 7 and P=1, so every frame gives an oPaso.
- iChoque at oVidas=3 -> oVidas=2, CHOQUE, oPintar toggles every 8 frames. After 60 frames -> CARGA, then JUEGO with oNivel unchanged.
- Three crashes -> oVidas=0 and FIN. A start event -> IDLE. A further start event -> oVidas=3 and oNivel=0.
- With SECUENCIADOR_PAUSA_EN: pause edge at frame count 5 -> no oPaso while paused. Resume -> first oPaso after 3 more iFrame pulses (P=8).
